// File: rtl/hg_orient_decoder.sv
// hg_orient_decoder
//   Decodes the 4-contact mercury tilt-switch cluster into a one-hot
//   orientation. The raw contacts pass through a two-flop synchroniser and
//   a programmable debounce window. The accepted pattern is then decoded
//   into the orientation register.
//
// Ports
//   clk         system clock (sole domain)
//   rst         synchronous reset, active low
//   hg_in[3:0]  raw mercury contacts, asynchronous to clk
//   orient[5:0] one-hot: 0 UNKNOWN, 1 FRONT/DOWN, 2 UP, 3 LEFT, 4 RIGHT, 5 BACK
//   orient_chg  single-cycle pulse in the cycle orient takes a new value
//   stable      registered copy of the debounce accept condition
//   chg_cnt[7:0] saturating orientation-change count
//
// Build option
//   HG_EVENT_CNT_EN : when defined, chg_cnt counts orient_chg pulses and
//                     saturates at 8'hFF. When undefined, chg_cnt is tied to 0.
module hg_orient_decoder #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = 8,
  parameter logic [3:0]  PAT_FRONT = 4'b0000,
  parameter logic [3:0]  PAT_BACK  = 4'b1111,
  parameter logic [3:0]  PAT_UP    = 4'b0110,
  parameter logic [3:0]  PAT_DOWN  = 4'b1001,
  parameter logic [3:0]  PAT_LEFT  = 4'b1100,
  parameter logic [3:0]  PAT_RIGHT = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hg_in,
  output logic [5:0] orient,
  output logic       orient_chg,
  output logic       stable,
  output logic [7:0] chg_cnt
);

  typedef enum logic [5:0] {
    OR_UNKNOWN = 6'b000001,
    OR_FRONT   = 6'b000010,
    OR_UP      = 6'b000100,
    OR_LEFT    = 6'b001000,
    OR_RIGHT   = 6'b010000,
    OR_BACK    = 6'b100000
  } orient_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [3:0]       s1, s2;
  logic             s1_v, s2_v;
  logic [3:0]       candidate;
  logic             cand_v;
  logic [CNT_W-1:0] db_cnt;
  logic             accept;

  orient_e          orient_q, orient_d;
  logic             chg_d;
  logic [5:0]       orient_bits;
  logic             is_onehot;

  // The valid flags track which sync stages hold real post-reset samples.
  // The first real sample then loads as a fresh candidate, so the window
  // after reset has the same latency as after any other input change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1   <= hg_in;
      s2   <= s1;
      s1_v <= 1'b1;
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      candidate <= '0;
      cand_v    <= 1'b0;
      db_cnt    <= '0;
    end else if (s2_v) begin
      if (!cand_v || (s2 != candidate)) begin
        candidate <= s2;
        cand_v    <= 1'b1;
        db_cnt    <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign accept = cand_v && (s2 == candidate) && (db_cnt == DB_LAST);

  assign orient_bits = orient_q;
  assign is_onehot   = (orient_bits != '0) &&
                       ((orient_bits & (orient_bits - 6'd1)) == '0);

  always_comb begin
    orient_d = orient_q;
    if (!is_onehot) begin
      orient_d = OR_FRONT;
    end else if (accept) begin
      if (candidate == PAT_BACK)
        orient_d = OR_BACK;
      else if (candidate == PAT_UP)
        orient_d = OR_UP;
      else if (candidate == PAT_LEFT)
        orient_d = OR_LEFT;
      else if (candidate == PAT_RIGHT)
        orient_d = OR_RIGHT;
      else if ((candidate == PAT_FRONT) || (candidate == PAT_DOWN))
        orient_d = OR_FRONT;
      else if (orient_q == OR_UNKNOWN)
        orient_d = OR_FRONT;
    end
    chg_d = (orient_d != orient_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      orient_q   <= OR_UNKNOWN;
      orient_chg <= 1'b0;
      stable     <= 1'b0;
    end else begin
      orient_q   <= orient_d;
      orient_chg <= chg_d;
      stable     <= accept;
    end
  end

  assign orient = orient_q;

`ifdef HG_EVENT_CNT_EN
  logic [7:0] chg_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst)
      chg_cnt_q <= '0;
    else if (chg_d && (chg_cnt_q != 8'hFF))
      chg_cnt_q <= chg_cnt_q + 8'd1;
  end

  assign chg_cnt = chg_cnt_q;
`else
  assign chg_cnt = '0;
`endif

endmodule
